// File: rtl/exec_wb_pkg.sv
// Shared constants for the execute/write-back sequencer.
// Optional Zero/Neg flag outputs are enabled by EXEC_WB_FLAGS_EN.
package exec_wb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 2;
    localparam int DEF_OP_W   = 3;
    localparam int DEF_IMM_W  = 16;

    localparam logic [DEF_OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [DEF_OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [DEF_OP_W-1:0] OP_AND = 3'b010;
    localparam logic [DEF_OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [DEF_OP_W-1:0] OP_SLT = 3'b100;
    localparam logic [DEF_OP_W-1:0] OP_XOR = 3'b101;
    localparam logic [DEF_OP_W-1:0] OP_LDI = 3'b110;
    localparam logic [DEF_OP_W-1:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/exec_wb_alu.sv
// Combinational ALU for the execute/write-back sequencer.
// Maps op/opA/opB/imm to a result and flags undefined opcodes.
module exec_wb_alu
    import exec_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int OP_W   = DEF_OP_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] res_o,
    output logic              ill_o
);

    always_comb begin
        res_o = '0;
        ill_o = 1'b0;
        unique case (op_i)
            OP_ADD: res_o = a_i + b_i;
            OP_SUB: res_o = a_i - b_i;
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_SLT: res_o = {{(DATA_W-1){1'b0}},
                             ($signed(a_i) < $signed(b_i))};
            OP_XOR: res_o = a_i ^ b_i;
            OP_LDI: res_o = DATA_W'(imm_i);
            default: ill_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_wb_unit.sv
// Multi-cycle execute/write-back sequencer driving an external RegFile.
// Define EXEC_WB_FLAGS_EN to add registered Zero/Neg result flags.
module exec_wb_unit
    import exec_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int OP_W   = DEF_OP_W,
    parameter int IMM_W  = DEF_IMM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [OP_W-1:0]   InOp,
    input  logic [REG_AW-1:0] InRs,
    input  logic [REG_AW-1:0] InRt,
    input  logic [REG_AW-1:0] InRd,
    input  logic [IMM_W-1:0]  InImm,
    output logic [REG_AW-1:0] ReadReg1,
    output logic [REG_AW-1:0] ReadReg2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    output logic [REG_AW-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              Done,
    output logic              IllegalOp
`ifdef EXEC_WB_FLAGS_EN
    ,
    output logic              Zero,
    output logic              Neg
`endif
);

    state_e state_q, state_d;

    logic [OP_W-1:0]   op_q;
    logic [REG_AW-1:0] rs_q, rt_q, rd_q;
    logic [IMM_W-1:0]  imm_q;
    logic [DATA_W-1:0] opa_q, opb_q, res_q;
    logic              ill_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_ill;
    logic              accept;

    logic              wr_en_q;
    logic [REG_AW-1:0] wr_reg_q;
    logic [DATA_W-1:0] wr_data_q;

    assign accept = (state_q == S_IDLE) && InValid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (InValid) state_d = S_READ;
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= InOp;
                rs_q  <= InRs;
                rt_q  <= InRt;
                rd_q  <= InRd;
                imm_q <= InImm;
            end
            if (state_q == S_READ) begin
                opa_q <= ReadData1;
                opb_q <= ReadData2;
            end
            if (state_q == S_EXEC) begin
                res_q <= alu_res;
                ill_q <= alu_ill;
            end
        end
    end

    exec_wb_alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .IMM_W  (IMM_W)
    ) u_alu (
        .op_i  (op_q),
        .a_i   (opa_q),
        .b_i   (opb_q),
        .imm_i (imm_q),
        .res_o (alu_res),
        .ill_o (alu_ill)
    );

    // Write port moves on the falling edge so RegWrite is stable
    // across the whole high phase of the posedge that leaves WB.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= (state_q == S_WB) && !ill_q;
            if ((state_q == S_WB) && !ill_q) begin
                wr_reg_q  <= rd_q;
                wr_data_q <= res_q;
            end
        end
    end

`ifdef EXEC_WB_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (state_q == S_EXEC) begin
            zero_q <= (alu_res == '0);
            neg_q  <= alu_res[DATA_W-1];
        end
    end

    assign Zero = zero_q;
    assign Neg  = neg_q;
`endif

    assign InReady   = (state_q == S_IDLE);
    assign ReadReg1  = rs_q;
    assign ReadReg2  = rt_q;
    assign WriteReg  = wr_reg_q;
    assign WriteData = wr_data_q;
    assign RegWrite  = wr_en_q & reset;
    assign Done      = (state_q == S_WB);
    assign IllegalOp = (state_q == S_WB) && ill_q;

endmodule

// File: tb/tb_exec_wb_unit.sv
// Directed bench for exec_wb_unit with a behavioural 4-entry RegFile.
// Expected values are hand-computed constants in each step.
module tb_exec_wb_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [2:0]  InOp = '0;
    logic [1:0]  InRs = '0;
    logic [1:0]  InRt = '0;
    logic [1:0]  InRd = '0;
    logic [15:0] InImm = '0;
    logic [1:0]  ReadReg1, ReadReg2, WriteReg;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic        RegWrite, Done, IllegalOp;
`ifdef EXEC_WB_FLAGS_EN
    logic        Zero, Neg;
`endif

    logic [31:0] rf [4];
    int          wr_cnt = 0;
    int          ntests = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    exec_wb_unit dut (
        .clk       (clk),
        .reset     (reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .InOp      (InOp),
        .InRs      (InRs),
        .InRt      (InRt),
        .InRd      (InRd),
        .InImm     (InImm),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .Done      (Done),
        .IllegalOp (IllegalOp)
`ifdef EXEC_WB_FLAGS_EN
        ,
        .Zero      (Zero),
        .Neg       (Neg)
`endif
    );

    // RegFile model: write on posedge when enabled, combinational read
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else if (RegWrite) begin
            rf[WriteReg] <= WriteData;
        end
    end

    assign ReadData1 = rf[ReadReg1];
    assign ReadData2 = rf[ReadReg2];

    always @(posedge clk) if (RegWrite) wr_cnt <= wr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [2:0] op, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [1:0] rd,
                       input logic [15:0] imm, input logic ill,
                       input logic [31:0] exp);
        int n;
        int w0;
        logic [31:0] old;
        old = rf[rd];
        w0 = wr_cnt;
        n = 0;
        while (!InReady && n < 8) begin tick(); n++; end
        chk("ready_wait", InReady, 1);
        InValid = 1'b1;
        InOp = op; InRs = rs; InRt = rt; InRd = rd; InImm = imm;
        tick();
        InValid = 1'b0;
        chk("busy", InReady, 0);
        n = 0;
        while (!Done && n < 8) begin tick(); n++; end
        chk("latency", n, 2);
        chk("done", Done, 1);
        chk("illegal", IllegalOp, ill);
        chk("wr_before_edge", RegWrite, 0);
        tick();
        chk("regwrite", RegWrite, !ill);
        chk("done_drop", Done, 0);
        chk("ready_after", InReady, 1);
        chk("wr_pulses", wr_cnt - w0, ill ? 0 : 1);
        if (!ill) begin
            chk("wreg", WriteReg, rd);
            chk("wdata", WriteData, exp);
            chk("rf_write", rf[rd], exp);
        end else begin
            chk("rf_keep", rf[rd], old);
        end
    endtask

    initial begin
        int w0;
        int ndone;
        int first;
        int last;
        int gap_bad;

        // 1: reset state
        #12;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_done", Done, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_illegal", IllegalOp, 0);
        #10 reset = 1'b1;
        tick();
        chk("rel_ready", InReady, 1);
        chk("rel_done", Done, 0);

        // 2: LDI r1,#5; LDI r2,#7; ADD r3=r1+r2
        run(3'b110, 2'd0, 2'd0, 2'd1, 16'd5, 1'b0, 32'h0000_0005);
        run(3'b110, 2'd0, 2'd0, 2'd2, 16'd7, 1'b0, 32'h0000_0007);
        run(3'b000, 2'd1, 2'd2, 2'd3, 16'd0, 1'b0, 32'h0000_000C);

        // 3: SUB r0=r1-r2; SLT r3=r0<r1; ADD r1=r1+r1
        run(3'b001, 2'd1, 2'd2, 2'd0, 16'd0, 1'b0, 32'hFFFF_FFFE);
        run(3'b100, 2'd0, 2'd1, 2'd3, 16'd0, 1'b0, 32'h0000_0001);
        run(3'b000, 2'd1, 2'd1, 2'd1, 16'd0, 1'b0, 32'h0000_000A);
        run(3'b101, 2'd1, 2'd3, 2'd2, 16'd0, 1'b0, 32'h0000_000B);
        run(3'b010, 2'd2, 2'd1, 2'd2, 16'd0, 1'b0, 32'h0000_000A);
        run(3'b011, 2'd2, 2'd3, 2'd2, 16'd0, 1'b0, 32'h0000_000B);
        run(3'b110, 2'd0, 2'd0, 2'd2, 16'hFFFF, 1'b0, 32'h0000_FFFF);

        // 4: undefined opcode, rd=3
        run(3'b111, 2'd1, 2'd2, 2'd3, 16'd0, 1'b1, 32'h0);
        chk("ill_r3", rf[3], 32'h0000_0001);
        chk("ill_wdata_hold", WriteData, 32'h0000_FFFF);

        // 5: InValid held high -> accepts every 4 cycles
        InValid = 1'b1;
        InOp = 3'b110; InRs = 2'd0; InRt = 2'd0;
        InRd = 2'd0; InImm = 16'h1234;
        ndone = 0; first = 0; last = 0; gap_bad = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (Done) begin
                if (ndone == 0) first = c;
                else if (c - last != 4) gap_bad++;
                last = c;
                ndone++;
            end
        end
        InValid = 1'b0;
        chk("stream_first", first, 3);
        chk("stream_count", ndone, 3);
        chk("stream_gap", gap_bad, 0);
        tick();
        chk("stream_rf", rf[0], 32'h0000_1234);
        chk("stream_ready", InReady, 1);

        // 6: reset during EXEC of LDI r2,#FF
        w0 = wr_cnt;
        InValid = 1'b1;
        InOp = 3'b110; InRd = 2'd2; InImm = 16'h00FF;
        tick();
        InValid = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_regwrite", RegWrite, 0);
        #10 reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("post_rst_regwrite", RegWrite, 0);
        end
        chk("post_rst_pulses", wr_cnt - w0, 0);
        chk("post_rst_r2", rf[2], 32'h0);
        chk("post_rst_ready", InReady, 1);
        chk("post_rst_done", Done, 0);

        // recovery after reset
        run(3'b110, 2'd0, 2'd0, 2'd2, 16'h00FF, 1'b0, 32'h0000_00FF);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
